// File: rtl/bp_be_stream_prefetch_generator.sv
// bp_be_stream_prefetch_generator
//   Tracks up to streams_p strided-load streams, keyed by load PC. Each stream
//   walks its address by a signed stride once per cycle and emits one
//   prefetch.r dispatch packet whenever the walk enters a new D$ block.
//
// Ports
//   clk_i, reset_n_i          clock, async active-low reset
//   flush_i                   cancel every stream; masks v_o this cycle
//   pc_i/eff_addr_i/stride_i/loop_counter_i, v_i/ready_and_o
//                             stream request (re-arms a matching PC,
//                             otherwise claims the lowest idle slot)
//   v_o/yumi_i, dispatch_pkt_o
//                             round-robin prefetch packet output
//
// Packet layout (MSB -> LSB):
//   v, nspec_v, pc[vaddr], instr[32], rs1[dpath], rs2[dpath], imm[dpath],
//   decode{pipe_mem_early_v, mem_v, dcache_r_v, spec_w_v, score_v,
//          irf_w_v, fu_op[6], prefetch}

// Per-stream walker: IDLE -> WALK (one stride per cycle) -> SEND (stalled
// until its packet is consumed).
module bp_be_stream_prefetch_slot
 #(parameter int vaddr_width_p  = 32
  ,parameter int loop_range_p   = 8
  ,parameter int stride_width_p = 12
  ,parameter int bo_p           = 6
  )
  (input  logic                      clk_i
  ,input  logic                      reset_n_i
  ,input  logic                      flush_i
  ,input  logic                      load_i
  ,input  logic                      send_done_i
  ,input  logic [vaddr_width_p-1:0]  pc_i
  ,input  logic [vaddr_width_p-1:0]  addr_i
  ,input  logic [stride_width_p-1:0] stride_i
  ,input  logic [loop_range_p-1:0]   cnt_i
  ,output logic                      idle_o
  ,output logic                      send_o
  ,output logic [vaddr_width_p-1:0]  pc_o
  ,output logic [vaddr_width_p-1:0]  addr_o
  );

  typedef enum logic [1:0] {e_idle, e_walk, e_send} state_e;

  state_e                          state_r;
  logic [vaddr_width_p-1:0]        pc_r, addr_r, addr_next;
  logic [stride_width_p-1:0]       stride_r;
  logic [loop_range_p-1:0]         cnt_r;
  logic [vaddr_width_p-1:bo_p]     blk_r;

  // Sign-extended stride; the add wraps modulo 2^vaddr.
  assign addr_next = addr_r
    + {{(vaddr_width_p-stride_width_p){stride_r[stride_width_p-1]}}, stride_r};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_idle;
      pc_r     <= '0;
      addr_r   <= '0;
      stride_r <= '0;
      cnt_r    <= '0;
      blk_r    <= '0;
    end else if (flush_i) begin
      state_r  <= e_idle;
    end else if (load_i) begin
      // A re-arm overrides whatever the slot was doing; a same-cycle yumi
      // has already been counted by the arbiter.
      state_r  <= e_walk;
      pc_r     <= pc_i;
      addr_r   <= addr_i;
      stride_r <= stride_i;
      cnt_r    <= cnt_i;
      blk_r    <= addr_i[vaddr_width_p-1:bo_p];
    end else begin
      case (state_r)
        e_walk: begin
          if (cnt_r == '0) begin
            state_r <= e_idle;
          end else begin
            addr_r <= addr_next;
            cnt_r  <= cnt_r - 1'b1;
            if (addr_next[vaddr_width_p-1:bo_p] != blk_r) begin
              blk_r   <= addr_next[vaddr_width_p-1:bo_p];
              state_r <= e_send;
            end
          end
        end
        e_send: if (send_done_i) state_r <= (cnt_r == '0) ? e_idle : e_walk;
        default: ;
      endcase
    end
  end

  assign idle_o = (state_r == e_idle);
  assign send_o = (state_r == e_send);
  assign pc_o   = pc_r;
  assign addr_o = addr_r;

endmodule

module bp_be_stream_prefetch_generator
 #(parameter int streams_p            = 4
  ,parameter int loop_range_p         = 8
  ,parameter int stride_width_p       = 12
  ,parameter int vaddr_width_p        = 32
  ,parameter int dpath_width_gp       = 64
  ,parameter int dcache_block_width_p = 512
  ,parameter int block_bytes_p        = dcache_block_width_p/8
  ,localparam int dispatch_pkt_width_lp = 2 + vaddr_width_p + 32 + 3*dpath_width_gp + 13
  )
  (input  logic                             clk_i
  ,input  logic                             reset_n_i
  ,input  logic                             flush_i
  ,input  logic [vaddr_width_p-1:0]         pc_i
  ,input  logic [dpath_width_gp-1:0]        eff_addr_i
  ,input  logic [stride_width_p-1:0]        stride_i
  ,input  logic [loop_range_p-1:0]          loop_counter_i
  ,input  logic                             v_i
  ,output logic                             ready_and_o
  ,output logic                             v_o
  ,input  logic                             yumi_i
  ,output logic [dispatch_pkt_width_lp-1:0] dispatch_pkt_o
  );

  localparam int bo_lp    = $clog2(block_bytes_p);
  localparam int idx_w_lp = (streams_p > 1) ? $clog2(streams_p) : 1;
  // prefetch.r: S-type, OP-IMM, funct3=110, rs2=00001
  localparam logic [31:0] prefetch_r_instr_lp = 32'h0010_6013;
  localparam logic [5:0]  fu_op_dcache_lb_lp  = 6'h00;

  logic [streams_p-1:0]                    idle, send, load, done, match;
  logic [streams_p-1:0][vaddr_width_p-1:0] slot_pc, slot_addr;
  logic                                    accept;
  int                                      sel, rr_j;
  logic [idx_w_lp-1:0]                     gnt_idx, rr_ptr_r, rr_nxt, lock_idx_r;
  logic                                    lock_v_r, hold;

  logic unused_eff;
  assign unused_eff = ^eff_addr_i[dpath_width_gp-1:vaddr_width_p];

  for (genvar i = 0; i < streams_p; i++) begin : slot
    assign match[i] = ~idle[i] & (slot_pc[i] == pc_i);
    assign done[i]  = v_o & yumi_i & (gnt_idx == idx_w_lp'(i));

    bp_be_stream_prefetch_slot
     #(.vaddr_width_p(vaddr_width_p), .loop_range_p(loop_range_p)
      ,.stride_width_p(stride_width_p), .bo_p(bo_lp))
     u_slot
      (.clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i)
      ,.load_i(load[i]), .send_done_i(done[i])
      ,.pc_i(pc_i), .addr_i(eff_addr_i[vaddr_width_p-1:0])
      ,.stride_i(stride_i), .cnt_i(loop_counter_i)
      ,.idle_o(idle[i]), .send_o(send[i])
      ,.pc_o(slot_pc[i]), .addr_o(slot_addr[i])
      );
  end

  assign ready_and_o = (|idle) | (|match);
  assign accept      = v_i & ready_and_o & ~flush_i;

  // A PC hit takes precedence over claiming a free slot.
  always_comb begin
    load = '0;
    sel  = 0;
    for (int i = streams_p-1; i >= 0; i--) if (idle[i])  sel = i;
    for (int i = streams_p-1; i >= 0; i--) if (match[i]) sel = i;
    if (accept) load[sel] = 1'b1;
  end

  // Round-robin from rr_ptr_r. While a packet is stalled the previous
  // winner is locked so a newly-sending slot ahead of it cannot steal the
  // grant and change the packet under the consumer.
  always_comb begin
    gnt_idx = '0;
    rr_j    = 0;
    hold    = lock_v_r & send[lock_idx_r];
    for (int i = streams_p-1; i >= 0; i--) begin
      rr_j = (int'(rr_ptr_r) + i) % streams_p;
      if (send[rr_j]) gnt_idx = idx_w_lp'(rr_j);
    end
    if (hold) gnt_idx = lock_idx_r;
  end

  assign rr_nxt = idx_w_lp'((int'(gnt_idx) + 1) % streams_p);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r   <= '0;
      lock_v_r   <= 1'b0;
      lock_idx_r <= '0;
    end else begin
      lock_v_r   <= v_o & ~yumi_i;
      lock_idx_r <= gnt_idx;
      if (v_o & yumi_i) rr_ptr_r <= rr_nxt;
    end
  end

  assign v_o = (|send) & ~flush_i;

  always_comb begin
    dispatch_pkt_o = '0;
    if (v_o)
      dispatch_pkt_o = {1'b1, 1'b1, slot_pc[gnt_idx], prefetch_r_instr_lp
                       ,dpath_width_gp'(slot_addr[gnt_idx])
                       ,{dpath_width_gp{1'b0}}, {dpath_width_gp{1'b0}}
                       ,5'b11111, 1'b0, fu_op_dcache_lb_lp, 1'b1};
  end

endmodule

// File: tb/tb_bp_be_stream_prefetch_generator.sv
module tb_bp_be_stream_prefetch_generator;

  localparam int PKT_W = 2 + 32 + 32 + 3*64 + 13;

  logic             clk_i = 1'b0;
  logic             reset_n_i, flush_i, v_i, yumi_i;
  logic [31:0]      pc_i;
  logic [63:0]      eff_addr_i;
  logic [11:0]      stride_i;
  logic [7:0]       loop_counter_i;
  logic             ready_and_o, v_o;
  logic [PKT_W-1:0] dispatch_pkt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_be_stream_prefetch_generator dut
    (.clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i)
    ,.pc_i(pc_i), .eff_addr_i(eff_addr_i), .stride_i(stride_i)
    ,.loop_counter_i(loop_counter_i), .v_i(v_i), .ready_and_o(ready_and_o)
    ,.v_o(v_o), .yumi_i(yumi_i), .dispatch_pkt_o(dispatch_pkt_o));

  typedef struct {
    logic [31:0]      pc, eff;
    logic [11:0]      stride;
    logic [7:0]       cnt;
    int               n;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [PKT_W-1:0] exp_pkt(input logic [31:0] pc, input logic [31:0] addr);
    return {1'b1, 1'b1, pc, 32'h0010_6013, 32'h0, addr, 64'h0, 64'h0,
            5'b11111, 1'b0, 6'h00, 1'b1};
  endfunction

  task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic req(input logic [31:0] pc, input logic [31:0] eff, input logic [11:0] stride,
                     input logic [7:0] cnt, input logic exp_ready);
    v_i = 1'b1; pc_i = pc; eff_addr_i = {32'h0, eff}; stride_i = stride; loop_counter_i = cnt;
    #1;
    chk("req_ready", PKT_W'(ready_and_o), PKT_W'(exp_ready));
    step();
    v_i = 1'b0;
  endtask

  task automatic wait_vo(input string nm);
    int c;
    c = 0;
    while (!v_o && c < 100) begin step(); c++; end
    chk(nm, PKT_W'(v_o), PKT_W'(1'b1));
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  initial begin #400000; $display("FAIL watchdog: got timeout expected finish"); $fatal(1); end

  initial begin
    logic seen;

    tbl[0] = '{pc:32'h80, eff:32'h1000,      stride:12'd8,   cnt:8'd16, n:2, exp:{32'h0, 32'h0, 32'h1080, 32'h1040}};
    tbl[1] = '{pc:32'h90, eff:32'h2000,      stride:12'hFC0, cnt:8'd3,  n:3, exp:{32'h0, 32'h1F40, 32'h1F80, 32'h1FC0}};
    tbl[2] = '{pc:32'h94, eff:32'h2000,      stride:12'd0,   cnt:8'd5,  n:0, exp:'0};
    tbl[3] = '{pc:32'h98, eff:32'h1000,      stride:12'd64,  cnt:8'd0,  n:0, exp:'0};
    tbl[4] = '{pc:32'hA0, eff:32'hFFFF_FFC0, stride:12'd64,  cnt:8'd2,  n:2, exp:{32'h0, 32'h0, 32'h40, 32'h0}};

    reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    pc_i = '0; eff_addr_i = '0; stride_i = '0; loop_counter_i = '0;
    #3;
    chk("reset_v_o",   PKT_W'(v_o),         PKT_W'(1'b0));
    chk("reset_ready", PKT_W'(ready_and_o), PKT_W'(1'b1));
    chk("reset_pkt",   dispatch_pkt_o,      '0);
    #9 reset_n_i = 1'b1;
    step();

    // single-stream vectors
    for (int k = 0; k < 5; k++) begin
      req(tbl[k].pc, tbl[k].eff, tbl[k].stride, tbl[k].cnt, 1'b1);
      for (int p = 0; p < tbl[k].n; p++) begin
        wait_vo($sformatf("vec%0d_pkt%0d_v", k, p));
        chk($sformatf("vec%0d_pkt%0d", k, p), dispatch_pkt_o, exp_pkt(tbl[k].pc, tbl[k].exp[p]));
        consume();
      end
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin seen |= v_o; step(); end
      chk($sformatf("vec%0d_quiet", k), PKT_W'(seen), '0);
    end

    // capacity and re-arm
    req(32'h80, 32'h1000, 12'd0, 8'd250, 1'b1);
    req(32'h84, 32'h1000, 12'd0, 8'd250, 1'b1);
    req(32'h88, 32'h1000, 12'd0, 8'd250, 1'b1);
    req(32'h8C, 32'h1000, 12'd0, 8'd250, 1'b1);
    pc_i = 32'h90; #1;
    chk("full_new_pc", PKT_W'(ready_and_o), PKT_W'(1'b0));
    pc_i = 32'h84; #1;
    chk("full_existing_pc", PKT_W'(ready_and_o), PKT_W'(1'b1));
    req(32'h80, 32'h3000, 12'd64, 8'd1, 1'b1);
    wait_vo("rearm_v");
    chk("rearm_pkt", dispatch_pkt_o, exp_pkt(32'h80, 32'h3040));

    // flush beats yumi and v_i while slot0 sends and 3 others walk
    flush_i = 1'b1; yumi_i = 1'b1; v_i = 1'b1;
    pc_i = 32'h200; eff_addr_i = 64'h0; stride_i = 12'd64; loop_counter_i = 8'd10;
    #1;
    chk("flush_v_o_mask", PKT_W'(v_o), PKT_W'(1'b0));
    step();
    flush_i = 1'b0; yumi_i = 1'b0; v_i = 1'b0;
    chk("flush_after_v_o", PKT_W'(v_o), PKT_W'(1'b0));
    chk("flush_after_ready", PKT_W'(ready_and_o), PKT_W'(1'b1));

    // all four slots free again; first crossing is visible two cycles after accept
    req(32'h300, 32'h0, 12'd64, 8'd10, 1'b1);
    chk("latency_t1", PKT_W'(v_o), PKT_W'(1'b0));
    req(32'h304, 32'h0, 12'd64, 8'd10, 1'b1);
    chk("latency_t2", PKT_W'(v_o), PKT_W'(1'b1));
    chk("latency_pkt", dispatch_pkt_o, exp_pkt(32'h300, 32'h40));
    req(32'h308, 32'h0, 12'd64, 8'd10, 1'b1);
    req(32'h30C, 32'h0, 12'd64, 8'd10, 1'b1);
    pc_i = 32'h200; #1;
    chk("flush_dropped_req", PKT_W'(ready_and_o), PKT_W'(1'b0));

    // asynchronous reset mid-SEND
    reset_n_i = 1'b0; #1;
    chk("async_rst_v_o",   PKT_W'(v_o),         PKT_W'(1'b0));
    chk("async_rst_pkt",   dispatch_pkt_o,      '0);
    chk("async_rst_ready", PKT_W'(ready_and_o), PKT_W'(1'b1));
    #1 reset_n_i = 1'b1;
    step();
    chk("post_rst_v_o", PKT_W'(v_o), PKT_W'(1'b0));

    // round-robin with all four slots in SEND
    req(32'h100, 32'h0, 12'd64, 8'd10, 1'b1);
    req(32'h104, 32'h0, 12'd64, 8'd10, 1'b1);
    req(32'h108, 32'h0, 12'd64, 8'd10, 1'b1);
    req(32'h10C, 32'h0, 12'd64, 8'd10, 1'b1);
    step(); step();
    yumi_i = 1'b1;
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("rr_%0d", r), dispatch_pkt_o,
          exp_pkt(32'h100 + 32'(4*(r%4)), (r < 4) ? 32'h40 : 32'h80));
      step();
    end
    yumi_i = 1'b0;

    // backpressure: slot1 holds its second packet
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold_%0d", c), dispatch_pkt_o, exp_pkt(32'h104, 32'h80));
      step();
    end
    consume();
    chk("bp_next", dispatch_pkt_o, exp_pkt(32'h108, 32'h80));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
